// File: rtl/ysyx_22050710_lsu_pkg.sv
// Shared LSU definitions: sequencer states, access-size codes and bus response codes.
package ysyx_22050710_lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RADDR = 3'd1,
      ST_RDATA = 3'd2,
      ST_WREQ  = 3'd3,
      ST_WRESP = 3'd4,
      ST_RESP  = 3'd5
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } lsu_size_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [2:0] MEMOP_RSVD  = 3'b111;
   localparam int         TIMEOUT_DEF = 255;

endpackage

// File: rtl/ysyx_22050710_lsu_align.sv
// Byte-lane helpers for one 64-bit bus word: alignment check, store lane
// placement (strobe + data) and load lane extraction.
module ysyx_22050710_lsu_align
   import ysyx_22050710_lsu_pkg::*;
(
   input  logic [2:0]  off,
   input  lsu_size_e   size,
   input  logic [63:0] wdata,
   input  logic [63:0] rdata,
   output logic        misaligned,
   output logic [7:0]  wstrb,
   output logic [63:0] wdata_sh,
   output logic [63:0] rdata_sh
);

   logic [2:0] low_mask;
   logic [7:0] byte_mask;

   always_comb begin
      low_mask  = 3'b000;
      byte_mask = 8'h01;
      case (size)
         SZ_B:    begin low_mask = 3'b000; byte_mask = 8'h01; end
         SZ_H:    begin low_mask = 3'b001; byte_mask = 8'h03; end
         SZ_W:    begin low_mask = 3'b011; byte_mask = 8'h0F; end
         default: begin low_mask = 3'b111; byte_mask = 8'hFF; end
      endcase
   end

   assign misaligned = |(off & low_mask);
   assign wstrb      = byte_mask << off;
   assign wdata_sh   = wdata << {off, 3'b000};
   assign rdata_sh   = rdata >> {off, 3'b000};

endmodule

// File: rtl/ysyx_22050710_lsu_ctrl.sv
// Load/store sequencer: takes one EXU request, runs it over the split
// read/write valid-ready bus, and returns a one-cycle completion with fault flag.
module ysyx_22050710_lsu_ctrl
   import ysyx_22050710_lsu_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_wen,
   input  logic [63:0] i_addr,
   input  logic [63:0] i_wdata,
   input  logic [2:0]  i_MemOP,
   output logic        o_resp_valid,
   output logic [63:0] o_rdata,
   output logic        o_fault,
   output logic        o_stall,
   output logic        o_mem_arvalid,
   input  logic        i_mem_arready,
   output logic [63:0] o_mem_araddr,
   input  logic        i_mem_rvalid,
   output logic        o_mem_rready,
   input  logic [63:0] i_mem_rdata,
   input  logic [1:0]  i_mem_rresp,
   output logic        o_mem_wvalid,
   input  logic        i_mem_wready,
   output logic [63:0] o_mem_waddr,
   output logic [63:0] o_mem_wdata,
   output logic [7:0]  o_mem_wstrb,
   input  logic        i_mem_bvalid,
   output logic        o_mem_bready,
   input  logic [1:0]  i_mem_bresp
);

   localparam int              CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);

   lsu_state_e    state_q, state_d;
   logic [CW-1:0] tmo_cnt;
   logic [63:0]   addr_p0, wdata_p0, rdata_q;
   lsu_size_e     size_p0;
   logic          rsvd_p0, fault_q;
   logic          misaligned, bad_req, accept, in_wait, tmo_hit, set_fault, rd_beat;
   logic [7:0]    wstrb;
   logic [63:0]   wdata_sh, rdata_sh;

   assign accept  = (state_q == ST_IDLE) & i_req_valid;
   assign bad_req = misaligned | rsvd_p0;
   assign in_wait = state_q inside {ST_RADDR, ST_RDATA, ST_WREQ, ST_WRESP};
   assign tmo_hit = in_wait & (tmo_cnt == TMO_LAST);

   ysyx_22050710_lsu_align u_align (
      .off        (addr_p0[2:0]),
      .size       (size_p0),
      .wdata      (wdata_p0),
      .rdata      (i_mem_rdata),
      .misaligned (misaligned),
      .wstrb      (wstrb),
      .wdata_sh   (wdata_sh),
      .rdata_sh   (rdata_sh)
   );

   // request capture stage
   always_ff @(posedge i_clk) begin
      if (accept) begin
         addr_p0  <= i_addr;
         wdata_p0 <= i_wdata;
         size_p0  <= lsu_size_e'(i_MemOP[2:1]);
         rsvd_p0  <= (i_MemOP == MEMOP_RSVD);
      end
   end

   // The first cycle after accept judges the captured request; a bad one
   // leaves without ever raising a bus valid.
   always_comb begin
      state_d   = state_q;
      set_fault = 1'b0;
      rd_beat   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_req_valid) state_d = i_wen ? ST_WREQ : ST_RADDR;
         end
         ST_RADDR: begin
            if (bad_req) begin
               state_d   = ST_RESP;
               set_fault = 1'b1;
            end else if (i_mem_arready) begin
               state_d = ST_RDATA;
            end else if (tmo_hit) begin
               state_d   = ST_RESP;
               set_fault = 1'b1;
            end
         end
         ST_RDATA: begin
            if (i_mem_rvalid) begin
               state_d   = ST_RESP;
               rd_beat   = 1'b1;
               set_fault = (i_mem_rresp != RESP_OKAY);
            end else if (tmo_hit) begin
               state_d   = ST_RESP;
               set_fault = 1'b1;
            end
         end
         ST_WREQ: begin
            if (bad_req) begin
               state_d   = ST_RESP;
               set_fault = 1'b1;
            end else if (i_mem_wready) begin
               state_d = ST_WRESP;
            end else if (tmo_hit) begin
               state_d   = ST_RESP;
               set_fault = 1'b1;
            end
         end
         ST_WRESP: begin
            if (i_mem_bvalid) begin
               state_d   = ST_RESP;
               set_fault = (i_mem_bresp != RESP_OKAY);
            end else if (tmo_hit) begin
               state_d   = ST_RESP;
               set_fault = 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // control / response stage
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         tmo_cnt <= '0;
         fault_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q) tmo_cnt <= '0;
         else if (in_wait)       tmo_cnt <= tmo_cnt + CW'(1);
         if (accept)         fault_q <= 1'b0;
         else if (set_fault) fault_q <= 1'b1;
         if (accept)       rdata_q <= '0;
         else if (rd_beat) rdata_q <= (i_mem_rresp == RESP_OKAY) ? rdata_sh : '0;
      end
   end

   assign o_req_ready   = (state_q == ST_IDLE);
   assign o_resp_valid  = (state_q == ST_RESP);
   assign o_fault       = o_resp_valid & fault_q;
   assign o_rdata       = rdata_q;
   assign o_stall       = ((state_q != ST_IDLE) & (state_q != ST_RESP)) | (o_req_ready & i_req_valid);

   // IDLE keeps both response channels ready so stray beats drain harmlessly.
   assign o_mem_arvalid = (state_q == ST_RADDR) & ~bad_req;
   assign o_mem_araddr  = {addr_p0[63:3], 3'b000};
   assign o_mem_rready  = (state_q == ST_IDLE) | (state_q == ST_RDATA);
   assign o_mem_wvalid  = (state_q == ST_WREQ) & ~bad_req;
   assign o_mem_waddr   = {addr_p0[63:3], 3'b000};
   assign o_mem_wdata   = wdata_sh;
   assign o_mem_wstrb   = wstrb;
   assign o_mem_bready  = (state_q == ST_IDLE) | (state_q == ST_WRESP);

endmodule

// File: tb/tb_ysyx_22050710_lsu_ctrl.sv
// Directed bench for the LSU sequencer: a phase-timeline model of each access
// is checked every cycle, plus literal expectations for the key scenarios.
module tb_ysyx_22050710_lsu_ctrl;

   localparam int TMO = 255;

   logic        i_clk = 1'b0;
   logic        i_rst_n, i_req_valid, i_wen;
   logic [63:0] i_addr, i_wdata;
   logic [2:0]  i_MemOP;
   logic        o_req_ready, o_resp_valid, o_fault, o_stall;
   logic [63:0] o_rdata;
   logic        o_mem_arvalid, i_mem_arready, i_mem_rvalid, o_mem_rready;
   logic [63:0] o_mem_araddr, i_mem_rdata;
   logic [1:0]  i_mem_rresp, i_mem_bresp;
   logic        o_mem_wvalid, i_mem_wready, i_mem_bvalid, o_mem_bready;
   logic [63:0] o_mem_waddr, o_mem_wdata;
   logic [7:0]  o_mem_wstrb;

   ysyx_22050710_lsu_ctrl #(.TIMEOUT(TMO)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_wen(i_wen),
      .i_addr(i_addr), .i_wdata(i_wdata), .i_MemOP(i_MemOP),
      .o_resp_valid(o_resp_valid), .o_rdata(o_rdata), .o_fault(o_fault), .o_stall(o_stall),
      .o_mem_arvalid(o_mem_arvalid), .i_mem_arready(i_mem_arready), .o_mem_araddr(o_mem_araddr),
      .i_mem_rvalid(i_mem_rvalid), .o_mem_rready(o_mem_rready), .i_mem_rdata(i_mem_rdata),
      .i_mem_rresp(i_mem_rresp),
      .o_mem_wvalid(o_mem_wvalid), .i_mem_wready(i_mem_wready), .o_mem_waddr(o_mem_waddr),
      .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
      .i_mem_bvalid(i_mem_bvalid), .o_mem_bready(o_mem_bready), .i_mem_bresp(i_mem_bresp)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   // model of the access in flight, expressed as a timeline of edges
   bit          act = 1'b0, mdl_skip = 1'b1;
   int          e_acc, e_p1, e_resp;
   bit          e_load, e_bad, e_fault;
   logic [63:0] e_baddr, e_wdata, e_rdata;
   logic [7:0]  e_wstrb;

   // observations captured inside run() for literal checks
   logic        cap_arvalid, cap_wvalid, r_fault, r_stall;
   logic [63:0] cap_araddr, cap_wdata, r_rdata;
   logic [7:0]  cap_wstrb;
   int          r_lat;

   task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
      checks++;
      if (act_v !== exp_v) begin
         fails++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act_v, exp_v, cyc);
      end
   endtask

   always @(negedge i_clk) begin : cmp
      bit in_acc, in_resp, ph1, ph2;
      if (!mdl_skip) begin
         if (act && cyc >= e_acc - 1 && cyc <= e_resp) begin
            in_acc  = (cyc == e_acc - 1);
            in_resp = (cyc == e_resp);
            ph1     = (cyc >= e_acc) && (cyc < e_p1);
            ph2     = (cyc >= e_p1) && (cyc < e_resp);
            chk("req_ready", o_req_ready, in_acc);
            chk("stall", o_stall, !in_resp);
            chk("resp_valid", o_resp_valid, in_resp);
            chk("arvalid", o_mem_arvalid, ph1 && e_load && !e_bad);
            chk("wvalid", o_mem_wvalid, ph1 && !e_load && !e_bad);
            if (ph1 && e_load && !e_bad) chk("araddr", o_mem_araddr, e_baddr);
            if (ph1 && !e_load && !e_bad) begin
               chk("waddr", o_mem_waddr, e_baddr);
               chk("wdata", o_mem_wdata, e_wdata);
               chk("wstrb", o_mem_wstrb, e_wstrb);
            end
            if (ph2) begin
               chk("rready", o_mem_rready, e_load);
               chk("bready", o_mem_bready, !e_load);
            end
            if (in_resp) begin
               chk("fault", o_fault, e_fault);
               chk("rdata", o_rdata, e_rdata);
            end
         end else begin
            chk("idle_req_ready", o_req_ready, 1);
            chk("idle_stall", o_stall, i_req_valid);
            chk("idle_resp_valid", o_resp_valid, 0);
            chk("idle_arvalid", o_mem_arvalid, 0);
            chk("idle_wvalid", o_mem_wvalid, 0);
            chk("idle_rready", o_mem_rready, 1);
            chk("idle_bready", o_mem_bready, 1);
         end
      end
   end

   // aw/dw: slave wait cycles before the address / data-or-response beat;
   // nar/nd: that beat never comes.
   task automatic run(input logic wen, input logic [63:0] addr, input logic [63:0] wd,
                      input logic [2:0] op, input int aw, input int dw, input logic [1:0] rsp,
                      input logic [63:0] sd, input bit nar, input bit nd);
      int sz, off, nbytes, p1, p2;
      bit bad, tmo, live;
      sz     = int'(op[2:1]);
      off    = int'(addr[2:0]);
      nbytes = 1 << sz;
      bad    = ((off % nbytes) != 0) || (op == 3'b111);
      tmo    = !bad && (nar || nd);
      p1     = bad ? 1 : (nar ? TMO : aw + 1);
      p2     = (bad || nar) ? 0 : (nd ? TMO : dw + 1);
      live   = !bad && !nar;
      e_acc  = cyc + 1;
      e_p1   = e_acc + p1;
      e_resp = e_p1 + p2;
      e_load = !wen;
      e_bad  = bad;
      e_baddr = addr & ~64'h7;
      e_wdata = wd << (8 * off);
      for (int b = 0; b < 8; b++) e_wstrb[b] = (b >= off) && (b < off + nbytes);
      e_fault = bad || tmo || (rsp != 2'b00);
      e_rdata = (!wen && !e_fault) ? (sd >> (8 * off)) : 64'd0;
      act = 1'b1;
      r_lat = 0;
      i_req_valid = 1'b1; i_wen = wen; i_addr = addr; i_wdata = wd; i_MemOP = op;
      while (cyc < e_resp) begin
         @(posedge i_clk); #2;
         if (cyc == e_acc) begin
            i_req_valid = 1'b0;
            cap_arvalid = o_mem_arvalid; cap_araddr = o_mem_araddr;
            cap_wvalid  = o_mem_wvalid;  cap_wdata  = o_mem_wdata; cap_wstrb = o_mem_wstrb;
         end
         if (o_resp_valid && r_lat == 0) r_lat = cyc - e_acc + 2;
         i_mem_arready = !wen && live && (cyc == e_acc + aw);
         i_mem_wready  =  wen && live && (cyc == e_acc + aw);
         i_mem_rvalid  = !wen && live && !nd && (cyc == e_p1 + dw);
         i_mem_bvalid  =  wen && live && !nd && (cyc == e_p1 + dw);
         i_mem_rdata   = i_mem_rvalid ? sd : 64'hDEAD_BEEF_0BAD_F00D;
         i_mem_rresp   = i_mem_rvalid ? rsp : 2'b11;
         i_mem_bresp   = i_mem_bvalid ? rsp : 2'b11;
      end
      r_rdata = o_rdata; r_fault = o_fault; r_stall = o_stall;
      @(posedge i_clk); #2;
      act = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      i_rst_n = 1'b0; i_req_valid = 1'b0; i_wen = 1'b0; i_addr = '0; i_wdata = '0; i_MemOP = '0;
      i_mem_arready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_mem_rresp = '0;
      i_mem_wready = 1'b0; i_mem_bvalid = 1'b0; i_mem_bresp = '0;
      repeat (3) @(posedge i_clk);
      #2;
      chk("rst_resp_valid", o_resp_valid, 0);
      chk("rst_fault", o_fault, 0);
      chk("rst_rdata", o_rdata, 0);
      chk("rst_arvalid", o_mem_arvalid, 0);
      chk("rst_wvalid", o_mem_wvalid, 0);
      chk("rst_req_ready", o_req_ready, 1);
      i_rst_n = 1'b1;
      mdl_skip = 1'b0;
      @(posedge i_clk); #2;

      run(1'b0, 64'h8000_0004, 64'd0, 3'b100, 0, 0, 2'b00, 64'h1122_3344_5566_7788, 1'b0, 1'b0);
      chk("lw_arvalid_lit", cap_arvalid, 1);
      chk("lw_araddr_lit", cap_araddr, 64'h8000_0000);
      chk("lw_rdata_lit", r_rdata, 64'h0000_0000_1122_3344);
      chk("lw_lat_lit", r_lat, 4);

      run(1'b1, 64'h8000_0006, 64'hABCD, 3'b010, 0, 1, 2'b00, 64'd0, 1'b0, 1'b0);
      chk("sh_wstrb_lit", cap_wstrb, 8'hC0);
      chk("sh_wdata_lit", cap_wdata[63:48], 16'hABCD);
      chk("sh_stall_resp_lit", r_stall, 0);
      chk("sh_fault_lit", r_fault, 0);

      run(1'b0, 64'h8000_0002, 64'd0, 3'b100, 0, 0, 2'b00, 64'h1, 1'b0, 1'b0);
      chk("mis_arvalid_lit", cap_arvalid, 0);
      chk("mis_fault_lit", r_fault, 1);
      chk("mis_lat_lit", r_lat, 3);

      run(1'b0, 64'h8000_0000, 64'd0, 3'b111, 0, 0, 2'b00, 64'h1, 1'b0, 1'b0);
      chk("rsvd_arvalid_lit", cap_arvalid, 0);
      chk("rsvd_fault_lit", r_fault, 1);

      run(1'b0, 64'h8000_0008, 64'd0, 3'b110, 5, 0, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
      chk("rerr_fault_lit", r_fault, 1);
      chk("rerr_rdata_lit", r_rdata, 0);

      run(1'b0, 64'h8000_0003, 64'd0, 3'b001, 1, 2, 2'b00, 64'h0102_0304_0506_0708, 1'b0, 1'b0);
      chk("lb_rdata_lit", r_rdata, 64'h0000_0001_0203_0405);

      run(1'b1, 64'h8000_0001, 64'h5A, 3'b000, 1, 0, 2'b00, 64'd0, 1'b0, 1'b0);
      chk("sb_wstrb_lit", cap_wstrb, 8'h02);
      chk("sb_wdata_lit", cap_wdata, 64'h5A00);

      run(1'b1, 64'h8000_000C, 64'h1234_5678, 3'b100, 2, 3, 2'b01, 64'd0, 1'b0, 1'b0);
      chk("berr_fault_lit", r_fault, 1);

      run(1'b1, 64'h8000_0004, 64'h77, 3'b110, 0, 0, 2'b00, 64'd0, 1'b0, 1'b0);
      chk("sd_mis_wvalid_lit", cap_wvalid, 0);
      chk("sd_mis_fault_lit", r_fault, 1);

      run(1'b0, 64'h8000_0020, 64'd0, 3'b110, 0, 0, 2'b00, 64'd0, 1'b0, 1'b1);
      chk("tmo_ld_fault_lit", r_fault, 1);
      chk("tmo_ld_lat_lit", r_lat, 2 + 1 + TMO);

      i_mem_rvalid = 1'b1; i_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF; i_mem_rresp = 2'b00;
      @(posedge i_clk); #2;
      i_mem_rvalid = 1'b0;
      chk("stray_rdata_lit", o_rdata, 0);
      chk("stray_resp_lit", o_resp_valid, 0);
      @(posedge i_clk); #2;

      run(1'b1, 64'h8000_0028, 64'h99, 3'b110, 0, 0, 2'b00, 64'd0, 1'b1, 1'b0);
      chk("tmo_st_fault_lit", r_fault, 1);
      chk("tmo_st_lat_lit", r_lat, 2 + TMO);

      mdl_skip = 1'b1;
      i_req_valid = 1'b1; i_wen = 1'b0; i_addr = 64'h8000_0010; i_MemOP = 3'b110;
      @(posedge i_clk); #2;
      i_req_valid = 1'b0; i_mem_arready = 1'b1;
      @(posedge i_clk); #2;
      i_mem_arready = 1'b0;
      chk("rst_mid_rready", o_mem_rready, 1);
      chk("rst_mid_stall", o_stall, 1);
      @(posedge i_clk); #2;
      i_rst_n = 1'b0;
      @(posedge i_clk); #2;
      chk("rst_mid_arvalid", o_mem_arvalid, 0);
      chk("rst_mid_wvalid", o_mem_wvalid, 0);
      chk("rst_mid_resp_valid", o_resp_valid, 0);
      chk("rst_mid_req_ready", o_req_ready, 1);
      chk("rst_mid_stall_lo", o_stall, 0);
      chk("rst_mid_rdata", o_rdata, 0);
      i_rst_n = 1'b1;
      mdl_skip = 1'b0;
      @(posedge i_clk); #2;

      run(1'b0, 64'h8000_0010, 64'd0, 3'b110, 0, 0, 2'b00, 64'hCAFE_F00D_1234_ABCD, 1'b0, 1'b0);
      chk("post_rst_rdata_lit", r_rdata, 64'hCAFE_F00D_1234_ABCD);
      chk("post_rst_fault_lit", r_fault, 0);

      repeat (2) @(posedge i_clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
